// File: rtl/rot_ctrl.sv
// Rotate engine top-level sequencer: validates and latches the image config, then walks
// the DMA through one read and one write phase per 8x8 set, with a per-phase watchdog.
//
// state   | meaning
// IDLE    | waiting for start
// CHECK   | validate latched dimensions
// CALC    | compute set total, pulse core start
// RD_REQ  | read phase requested, waiting for grant
// RD_WAIT | read phase running, waiting for done
// WR_REQ  | write phase requested, waiting for grant
// WR_WAIT | write phase running, waiting for done
// FIN     | completion pulse
// ERR     | error exit

module rot_ctrl #(
    parameter logic [15:0] P_TIMEOUT = 16'hFFFF,
    parameter logic [15:0] P_MAX_H   = 16'h7FFF,
    parameter logic [15:0] P_MAX_W   = 16'h3FFF
) (
    input  logic        I_RC_HCLK,
    input  logic        I_RC_RESET,
    input  logic        I_RC_START,
    input  logic [15:0] I_RC_HEIGHT,
    input  logic [15:0] I_RC_WIDTH,
    input  logic [1:0]  I_RC_DEGREES,
    input  logic        I_RC_DIRECTION,
    input  logic        I_RC_ABORT,
    input  logic        I_RC_IRQ_CLR,
    input  logic        I_RC_DMA_GRANT,
    input  logic        I_RC_DMA_DONE,
    output logic        O_RC_CS_START,
    output logic        O_RC_DMA_REQ,
    output logic        O_RC_DMA_WRITE,
    output logic [15:0] O_RC_HEIGHT,
    output logic [15:0] O_RC_WIDTH,
    output logic [1:0]  O_RC_DEGREES,
    output logic        O_RC_DIRECTION,
    output logic [23:0] O_RC_SET_CNT,
    output logic        O_RC_BUSY,
    output logic        O_RC_DONE,
    output logic        O_RC_IRQ,
    output logic [1:0]  O_RC_ERR
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_CALC,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_FIN,
        S_ERR
    } state_t;

    state_t      state;
    logic [23:0] total;
    logic [15:0] wdog;
    logic [12:0] h_sets;
    logic [12:0] w_sets;
    logic [23:0] set_next;
    logic        wdog_tc;
    logic        dims_bad;
    logic        abort_hit;

    assign h_sets    = O_RC_HEIGHT[15:3] + {12'd0, |O_RC_HEIGHT[2:0]};
    assign w_sets    = O_RC_WIDTH[15:3]  + {12'd0, |O_RC_WIDTH[2:0]};
    assign set_next  = O_RC_SET_CNT + 24'd1;
    assign wdog_tc   = (wdog == P_TIMEOUT - 16'd1);
    assign dims_bad  = (O_RC_HEIGHT == 16'd0) || (O_RC_WIDTH == 16'd0) ||
                       (O_RC_HEIGHT > P_MAX_H) || (O_RC_WIDTH > P_MAX_W);
    // FIN and ERR are already on their way out, so an abort there changes nothing
    assign abort_hit = I_RC_ABORT && (state != S_IDLE) && (state != S_FIN) && (state != S_ERR);

    always_ff @(posedge I_RC_HCLK) begin
        if (I_RC_RESET) begin
            state          <= S_IDLE;
            total          <= 24'd0;
            wdog           <= 16'd0;
            O_RC_CS_START  <= 1'b0;
            O_RC_DMA_REQ   <= 1'b0;
            O_RC_DMA_WRITE <= 1'b0;
            O_RC_HEIGHT    <= 16'd0;
            O_RC_WIDTH     <= 16'd0;
            O_RC_DEGREES   <= 2'd0;
            O_RC_DIRECTION <= 1'b0;
            O_RC_SET_CNT   <= 24'd0;
            O_RC_BUSY      <= 1'b0;
            O_RC_DONE      <= 1'b0;
            O_RC_IRQ       <= 1'b0;
            O_RC_ERR       <= 2'b00;
        end else begin
            O_RC_CS_START <= 1'b0;
            O_RC_DONE     <= 1'b0;

            // set has priority over clear
            if (state == S_FIN || state == S_ERR) begin
                O_RC_IRQ <= 1'b1;
            end else if (I_RC_IRQ_CLR) begin
                O_RC_IRQ <= 1'b0;
            end

            if (abort_hit) begin
                state        <= S_ERR;
                O_RC_ERR     <= 2'b11;
                O_RC_DMA_REQ <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (I_RC_START) begin
                            O_RC_HEIGHT    <= I_RC_HEIGHT;
                            O_RC_WIDTH     <= I_RC_WIDTH;
                            O_RC_DEGREES   <= I_RC_DEGREES;
                            O_RC_DIRECTION <= I_RC_DIRECTION;
                            O_RC_ERR       <= 2'b00;
                            O_RC_SET_CNT   <= 24'd0;
                            O_RC_BUSY      <= 1'b1;
                            state          <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (dims_bad) begin
                            O_RC_ERR <= 2'b01;
                            state    <= S_ERR;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        total          <= {11'd0, h_sets} * {11'd0, w_sets};
                        O_RC_CS_START  <= 1'b1;
                        O_RC_DMA_REQ   <= 1'b1;
                        O_RC_DMA_WRITE <= 1'b0;
                        wdog           <= 16'd0;
                        state          <= S_RD_REQ;
                    end
                    S_RD_REQ, S_WR_REQ: begin
                        if (I_RC_DMA_GRANT) begin
                            O_RC_DMA_REQ <= 1'b0;
                            wdog         <= 16'd0;
                            state        <= (state == S_RD_REQ) ? S_RD_WAIT : S_WR_WAIT;
                        end else if (wdog_tc) begin
                            O_RC_DMA_REQ <= 1'b0;
                            O_RC_ERR     <= 2'b10;
                            state        <= S_ERR;
                        end else begin
                            wdog <= wdog + 16'd1;
                        end
                    end
                    S_RD_WAIT: begin
                        if (I_RC_DMA_DONE) begin
                            O_RC_DMA_REQ   <= 1'b1;
                            O_RC_DMA_WRITE <= 1'b1;
                            wdog           <= 16'd0;
                            state          <= S_WR_REQ;
                        end else if (wdog_tc) begin
                            O_RC_ERR <= 2'b10;
                            state    <= S_ERR;
                        end else begin
                            wdog <= wdog + 16'd1;
                        end
                    end
                    S_WR_WAIT: begin
                        if (I_RC_DMA_DONE) begin
                            O_RC_SET_CNT <= set_next;
                            if (set_next == total) begin
                                O_RC_DONE <= 1'b1;
                                state     <= S_FIN;
                            end else begin
                                O_RC_DMA_REQ   <= 1'b1;
                                O_RC_DMA_WRITE <= 1'b0;
                                wdog           <= 16'd0;
                                state          <= S_RD_REQ;
                            end
                        end else if (wdog_tc) begin
                            O_RC_ERR <= 2'b10;
                            state    <= S_ERR;
                        end else begin
                            wdog <= wdog + 16'd1;
                        end
                    end
                    S_FIN, S_ERR: begin
                        O_RC_BUSY <= 1'b0;
                        state     <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/rot_ctrl.md
Name: rot_ctrl

Overview:
Top-level sequencer for the rotate engine. It accepts a start command and image config from the register file, then validates and latches the config. It computes the number of 8x8 pixel sets and drives the DMA through alternating read/write phases, one read phase and one write phase per set. It reports busy/done/error status and raises an interrupt, and it bounds every DMA phase with a watchdog.

Parameters:
P_TIMEOUT, 16'hFFFF, max cycles waiting for grant or phase completion before timeout error
P_MAX_H, 16'h7FFF, largest legal input height
P_MAX_W, 16'h3FFF, largest legal input width

Ports:
I_RC_HCLK  input  1  clock; all state changes on rising edge
I_RC_RESET  input  1  synchronous, active-high reset
I_RC_START  input  1  start pulse from register file
I_RC_HEIGHT  input  16  input image height in pixels
I_RC_WIDTH  input  16  input image width in pixels
I_RC_DEGREES  input  2  rotation select, 0/90/180/270
I_RC_DIRECTION  input  1  rotation direction
I_RC_ABORT  input  1  software abort, level
I_RC_IRQ_CLR  input  1  interrupt clear pulse
I_RC_DMA_GRANT  input  1  DMA accepted current phase request
I_RC_DMA_DONE  input  1  DMA finished current phase, 1-cycle pulse
O_RC_CS_START  output  1  1-cycle pulse to core: begin image
O_RC_DMA_REQ  output  1  phase request to DMA
O_RC_DMA_WRITE  output  1  0 = read phase, 1 = write phase
O_RC_HEIGHT  output  16  latched height
O_RC_WIDTH  output  16  latched width
O_RC_DEGREES  output  2  latched degrees
O_RC_DIRECTION  output  1  latched direction
O_RC_SET_CNT  output  24  sets completed
O_RC_BUSY  output  1  operation in progress
O_RC_DONE  output  1  1-cycle completion pulse
O_RC_IRQ  output  1  sticky interrupt
O_RC_ERR  output  2  00 none, 01 bad dims, 10 timeout, 11 aborted

Behaviour:
- Reset: every output 0, state IDLE, internal total/watchdog 0. Reset mid-operation also forces all of these values on the next edge, including O_RC_DMA_REQ.
- States: IDLE, CHECK, CALC, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN, ERR.
- IDLE: I_RC_START=1 -> latch the four config inputs, clear O_RC_ERR and O_RC_SET_CNT, go to CHECK. START is ignored in any other state.
- CHECK (1 cycle): height or width = 0, height > P_MAX_H, or width > P_MAX_W -> ERR with code 01. Otherwise -> CALC.
- CALC (1 cycle): total = ceil(H/8) * ceil(W/8), registered as 24 bits. The maximum is 4096*2048 = 2^23, so there is no overflow. Then -> RD_REQ, with O_RC_CS_START pulsed in the same cycle the RD_REQ transition is registered.
- O_RC_BUSY = 1 in every state except IDLE.
- RD_REQ: O_RC_DMA_REQ=1, O_RC_DMA_WRITE=0. On GRANT -> RD_WAIT; REQ drops the cycle after GRANT is sampled.
- RD_WAIT: on DMA_DONE -> WR_REQ.
- WR_REQ / WR_WAIT: same as the read pair with O_RC_DMA_WRITE=1.
- On DMA_DONE in WR_WAIT: O_RC_SET_CNT increments. If the new count = total -> FIN, else -> RD_REQ.
- DMA_DONE outside a WAIT state is ignored. GRANT outside a REQ state is ignored.
- O_RC_DMA_WRITE holds its value through the WAIT state.
- Watchdog: clears on entry to every REQ and WAIT state and counts each cycle in those states. Reaching P_TIMEOUT -> ERR with code 10, and REQ deasserts.
- FIN (1 cycle): O_RC_DONE=1, set IRQ, -> IDLE. Latched config and O_RC_SET_CNT hold their values until the next START.
- ERR (1 cycle): set IRQ, -> IDLE. O_RC_ERR holds its value until the next START.
- Abort: I_RC_ABORT=1 in any busy state except FIN/ERR -> ERR with code 11, and REQ drops the next cycle. Abort in FIN has no effect: completion wins. Abort in IDLE has no effect.
- IRQ: set by FIN/ERR, cleared by IRQ_CLR. If set and clear occur in the same cycle, set wins.
- START and ABORT in the same IDLE cycle: START is taken, and ABORT is then acted on in CHECK -> ERR 11.

Test Plan:
- H=16, W=16, deg=1, dir=1, START; DMA grants after 2 cycles and DONEs after 64 -> CS_START pulses once; 4 read/write phase pairs alternate with REQ/WRITE correct; SET_CNT reaches 4; DONE pulses 1 cycle; IRQ=1; ERR=00.
- H=10, W=17 -> total = 2*3 = 6 sets; exactly 12 DMA phases before DONE.
- H=16'h8000, W=8 -> ERR=01 two cycles after START; REQ never asserts; CS_START never pulses; IRQ=1. Repeat with W=0 -> same result.
- Withhold GRANT with P_TIMEOUT overridden to 20 -> REQ drops and ERR=10 exactly 20 cycles after RD_REQ entry; BUSY=0 next cycle.
- Assert ABORT during the 3rd WR_WAIT -> ERR=11; SET_CNT=2; REQ=0; a later DMA_DONE is ignored. A new START clears ERR and SET_CNT.
- START pulse while busy is ignored and latched config is unchanged. IRQ_CLR in the FIN cycle leaves IRQ=1; IRQ_CLR one cycle later gives IRQ=0. Reset asserted during RD_WAIT -> all outputs 0 next edge.
